// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the bus read logic.
// First-word-fall-through head, sticky overrun/frame-error status, level interrupt.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          frame_err_in,
    output logic          full,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [AW:0]   thresh,
    input  logic          clr_status,
    output logic          overrun,
    output logic          frame_err,
    output logic          irq
);

    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          push_s, pop_s;

    // full/empty come from the level counter so pointer equality is never ambiguous
    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == {(AW+1){1'b0}});
    assign push_s  = wr_en && !full;
    assign pop_s   = rd_en && !empty;

    assign level     = level_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign irq       = ((thresh != {(AW+1){1'b0}}) && (level_q >= thresh))
                       || overrun_q || frame_err_q;

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state for pointers, level and sticky status (a set event beats clear)
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (wr_en && full) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (frame_err_in) begin
            frame_err_d = 1'b1;
        end else if (clr_status) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {(AW+1){1'b0}};
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on push, checked on pop
// and against the FWFT head after every clock.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       frame_err_in;
    logic       full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic [4:0] level;
    logic [4:0] thresh;
    logic       clr_status;
    logic       overrun;
    logic       frame_err;
    logic       irq;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    int         m_level = 0;
    logic       m_ovr   = 1'b0;
    logic       m_fe    = 1'b0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .frame_err_in (frame_err_in),
        .full         (full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .level        (level),
        .thresh       (thresh),
        .clr_status   (clr_status),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string where);
        logic [7:0] head;
        logic       m_irq;
        head  = (sb.size() > 0) ? sb[0] : 8'h00;
        m_irq = ((thresh != 5'd0) && (m_level >= int'(thresh))) || m_ovr || m_fe;
        check_val({where, ".level"},     32'(level),     32'(m_level));
        check_val({where, ".empty"},     32'(empty),     32'(m_level == 0));
        check_val({where, ".full"},      32'(full),      32'(m_level == 16));
        check_val({where, ".rd_data"},   32'(rd_data),   32'(head));
        check_val({where, ".overrun"},   32'(overrun),   32'(m_ovr));
        check_val({where, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        check_val({where, ".irq"},       32'(irq),       32'(m_irq));
    endtask

    task automatic step(input string where, input logic we, input logic [7:0] wd,
                        input logic re, input logic fe, input logic cs);
        logic       push_ok;
        logic       pop_ok;
        logic [7:0] exp_b;
        push_ok = we && (m_level < 16);
        pop_ok  = re && (m_level > 0);
        if (pop_ok) begin
            exp_b = sb.pop_front();
            check_val({where, ".pop_data"}, 32'(rd_data), 32'(exp_b));
        end
        if (push_ok) sb.push_back(wd);
        if (we && (m_level == 16)) m_ovr = 1'b1;
        else if (cs)               m_ovr = 1'b0;
        if (fe)      m_fe = 1'b1;
        else if (cs) m_fe = 1'b0;
        if (push_ok && !pop_ok) m_level++;
        if (pop_ok && !push_ok) m_level--;

        wr_en = we; wr_data = wd; rd_en = re; frame_err_in = fe; clr_status = cs;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; frame_err_in = 1'b0; clr_status = 1'b0;
        check_state(where);
    endtask

    task automatic drain(input string where);
        for (int i = 0; i < 20; i++) begin
            if (sb.size() > 0) step(where, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        frame_err_in = 1'b0; clr_status = 1'b0; thresh = 5'd0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset");

        // 1: single byte round trip
        step("t1.push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check_val("t1.head", 32'(rd_data), 32'h0000_00A5);
        step("t1.pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_val("t1.empty_data", 32'(rd_data), 32'h0000_0000);

        // 2: fill, overrun, drain in order
        for (int i = 0; i < 16; i++) step("t2.fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_val("t2.full", 32'(full), 32'h1);
        step("t2.ovr", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check_val("t2.irq", 32'(irq), 32'h1);
        drain("t2.drain");
        step("t2.clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // 3: steady level 15 with pointer wrap
        for (int i = 0; i < 15; i++) step("t3.fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("t3.pp", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
        check_val("t3.level", 32'(level), 32'd15);
        drain("t3.drain");

        // 4: simultaneous push/pop at full and at empty
        for (int i = 0; i < 16; i++) step("t4.fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step("t4.full_pp", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        check_val("t4.full_level", 32'(level), 32'd15);
        check_val("t4.full_ovr", 32'(overrun), 32'h1);
        drain("t4.drain");
        step("t4.clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("t4.empty_pp", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check_val("t4.empty_level", 32'(level), 32'd1);
        check_val("t4.empty_data", 32'(rd_data), 32'h77);
        drain("t4.drain2");

        // 5: threshold interrupt and sticky frame error
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) step("t5.push", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        check_val("t5.irq_lo", 32'(irq), 32'h0);
        step("t5.push4", 1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        check_val("t5.irq_hi", 32'(irq), 32'h1);
        step("t5.fe_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_val("t5.fe_set", 32'(frame_err), 32'h1);
        step("t5.clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("t5.fe_clr", 32'(frame_err), 32'h0);
        drain("t5.drain");
        thresh = 5'd0;
        step("t5.idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step("t6.push", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        step("t6.fe", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6.level", 32'(level), 32'd0);
        check_val("t6.empty", 32'(empty), 32'h1);
        check_val("t6.full", 32'(full), 32'h0);
        check_val("t6.frame_err", 32'(frame_err), 32'h0);
        check_val("t6.overrun", 32'(overrun), 32'h0);
        check_val("t6.irq", 32'(irq), 32'h0);
        check_val("t6.rd_data", 32'(rd_data), 32'h0);
        sb.delete(); m_level = 0; m_ovr = 1'b0; m_fe = 1'b0;
        #4 rst_n = 1'b1;
        step("t6.after", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
